weighted_rr_issue_scheduler: RTL and testbench
==============================================

Name: weighted_rr_issue_scheduler

Overview:
- Shares one downstream issue slot (cache request port) among NUM_REQUESTS requesters.
- Weighted round-robin: each owner may issue up to its programmed weight of back-to-back requests before ownership rotates.
- Single registered output stage with valid/ack handshake toward the cache pipeline; per-requester one-hot consume pulse back to the sources.
- Sits between L1 miss/writeback/prefetch sources and the unified cache request input.

Parameters:
NUM_REQUESTS, 3, number of requesters (2..8)
SINGLE_REQUEST_WIDTH_IN_BITS, 64, payload width per requester
WEIGHT_WIDTH, 4, width of each per-requester weight field
STARVE_LIMIT, 15, waiting captures before a valid requester is forced (1..255)

Ports:
clk_in  input  1  clock, all state on rising edge
reset_in  input  1  synchronous active-high reset
request_packed_in  input  SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUESTS  payloads, requester i at bits [(i+1)*W-1 : i*W]
request_valid_packed_in  input  NUM_REQUESTS  per-requester valid
request_weight_packed_in  input  WEIGHT_WIDTH*NUM_REQUESTS  quasi-static weights; 0 treated as 1
issue_ack_out  output  NUM_REQUESTS  combinational one-hot consume pulse
request_out  output  SINGLE_REQUEST_WIDTH_IN_BITS  registered payload to cache
request_valid_out  output  1  registered valid to cache
issue_ack_in  input  1  cache accepts request_out this cycle
owner_out  output  clog2(NUM_REQUESTS) (min 1)  current round-robin owner index

Behaviour:
- Reset: request_out=0, request_valid_out=0, owner_out=NUM_REQUESTS-1 (first rotation lands on 0), credit=0, starvation counters=0; issue_ack_out=0 while reset_in high.
- slot_free = ~request_valid_out | issue_ack_in. Capture only when slot_free and some valid bit set.
- Selection priority at capture:
  1. Starved: lowest index i with valid[i] and starve_cnt[i]==STARVE_LIMIT.
  2. Continue: owner valid and credit!=0; credit decrements.
  3. Rotate: first valid index after owner, circular search from owner+1 wrapping through owner itself; owner<=winner, credit<=max(weight,1)-1.
- A starved grant sets owner<=winner and credit<=max(weight,1)-1, i.e. it behaves as a rotate.
- Capture edge: request_out<=payload[winner], request_valid_out<=1; issue_ack_out[winner]=1 combinationally in the same cycle, and the requester treats its payload as consumed at that edge.
- No capture and slot_free: request_valid_out<=0, request_out held (don't care), owner/credit held.
- Slot not free (valid_out=1, ack_in=0): all outputs held, issue_ack_out=0.
- Zero bubble: ack_in and a new capture in the same cycle sustain 1 request/cycle.
- Owner drops valid with credit left: credit discarded, rotate on the next capture.
- Starvation counter i, updated only on capture cycles:
  - cleared if i is granted or valid[i]=0;
  - otherwise incremented, saturating at STARVE_LIMIT.
- Weight changes take effect at the next rotation only.
- Reset mid-transfer drops a pending request_out with no ack to its source; the source has already been consumed.

Optional Feature:
STARVE_GUARD_EN
- Defined: starvation counters and priority step 1 as above.
- Undefined: no counters, pure weighted RR; STARVE_LIMIT unused; ports identical.

Test Plan:
- Weights {1,1,1}, all valid, ack_in=1 constantly -> grant order 0,1,2,0,1,2; one issue_ack_out bit per cycle; request_valid_out continuously 1 from cycle 2.
- Weights {3,1,1}, all valid, ack_in=1 -> order 0,0,0,1,2,0,0,0; owner_out follows.
- Requester 1 valid, ack_in held 0 for 5 cycles after first capture -> request_out and valid stable; issue_ack_out=0 throughout; second capture on the ack_in cycle.
- Weight0=15, STARVE_LIMIT=4, STARVE_GUARD_EN defined, all valid -> requester 1 granted after 4 consecutive grants to 0 (cycle 5), not after 15.
- Same stimulus with STARVE_GUARD_EN undefined -> 15 grants to 0, then 1.
- reset_in asserted while request_valid_out=1 -> next cycle valid_out=0, owner_out=NUM_REQUESTS-1; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/weighted_rr_issue_scheduler_if.sv
// weighted_rr_issue_scheduler_if
// Bundles the requester-side and cache-side signals of the weighted
// round-robin issue scheduler. The scheduler uses the slave modport.
// The surrounding environment (sources plus cache pipeline) uses master.
interface weighted_rr_issue_scheduler_if #(
  parameter int NUM_REQUESTS                 = 3,
  parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
  parameter int WEIGHT_WIDTH                 = 4
);
  localparam int OWNER_WIDTH = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;

  logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUESTS-1:0] request_packed_in;
  logic [NUM_REQUESTS-1:0]                              request_valid_packed_in;
  logic [WEIGHT_WIDTH*NUM_REQUESTS-1:0]                 request_weight_packed_in;
  logic [NUM_REQUESTS-1:0]                              issue_ack_out;
  logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]              request_out;
  logic                                                 request_valid_out;
  logic                                                 issue_ack_in;
  logic [OWNER_WIDTH-1:0]                               owner_out;

  modport slave (
    input  request_packed_in,
    input  request_valid_packed_in,
    input  request_weight_packed_in,
    input  issue_ack_in,
    output issue_ack_out,
    output request_out,
    output request_valid_out,
    output owner_out
  );

  modport master (
    output request_packed_in,
    output request_valid_packed_in,
    output request_weight_packed_in,
    output issue_ack_in,
    input  issue_ack_out,
    input  request_out,
    input  request_valid_out,
    input  owner_out
  );
endinterface

// File: rtl/weighted_rr_issue_scheduler.sv
// weighted_rr_issue_scheduler
// Shares one cache request slot among NUM_REQUESTS sources using weighted
// round-robin. The current owner may issue up to max(weight,1) back-to-back
// requests before ownership rotates. The output is a single registered stage
// with a valid/ack handshake. The consume pulse back to the sources
// (issue_ack_out) is combinational and fires on the capture cycle.
// Optional feature macro: STARVE_GUARD_EN. When it is defined, a requester
// that has waited STARVE_LIMIT captures is forced ahead of the normal order.
module weighted_rr_issue_scheduler #(
  parameter int NUM_REQUESTS                 = 3,
  parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
  parameter int WEIGHT_WIDTH                 = 4,
  parameter int STARVE_LIMIT                 = 15
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  weighted_rr_issue_scheduler_if.slave bus
);
  localparam int OWNER_W = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;
  localparam int PW      = SINGLE_REQUEST_WIDTH_IN_BITS;
  localparam int WW      = WEIGHT_WIDTH;
  localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NUM_REQUESTS - 1);
  localparam logic [OWNER_W:0]   NUM_W    = (OWNER_W+1)'(NUM_REQUESTS);

  // A programmed weight of 0 behaves like 1, so the reload is max(w,1)-1.
  function automatic logic [WW-1:0] reload_credit(input logic [WW-1:0] weight);
    reload_credit = (weight == {WW{1'b0}}) ? {WW{1'b0}} : (weight - WW'(1));
  endfunction

  logic [PW-1:0]           r_request_out;
  logic                    r_request_valid;
  logic [OWNER_W-1:0]      r_owner;
  logic [WW-1:0]           r_credit;

  logic                    w_slot_free;
  logic                    w_capture;
  logic                    w_starve_hit;
  logic [OWNER_W-1:0]      w_starve_idx;
  logic                    w_rot_hit;
  logic                    w_rot_take;
  logic [OWNER_W:0]        w_rot_sum;
  logic [OWNER_W-1:0]      w_rot_cand;
  logic [OWNER_W-1:0]      w_rot_idx;
  logic                    w_continue;
  logic                    w_rotate;
  logic [OWNER_W-1:0]      w_winner;
  logic [NUM_REQUESTS-1:0] w_grant_onehot;
  logic [PW-1:0]           w_payload;
  logic [WW-1:0]           w_win_weight;

  // Reset gates captures so no consume pulse leaks out while reset_in is high.
  assign w_slot_free = ~r_request_valid | bus.issue_ack_in;
  assign w_capture   = w_slot_free & (|bus.request_valid_packed_in) & ~reset_in;

  // Circular search from owner+1, wrapping through the owner itself.
  always_comb begin
    w_rot_hit  = 1'b0;
    w_rot_take = 1'b0;
    w_rot_sum  = '0;
    w_rot_cand = '0;
    w_rot_idx  = r_owner;
    for (int k = 1; k <= NUM_REQUESTS; k++) begin
      w_rot_sum  = {1'b0, r_owner} + (OWNER_W+1)'(k);
      w_rot_sum  = (w_rot_sum >= NUM_W) ? (w_rot_sum - NUM_W) : w_rot_sum;
      w_rot_cand = w_rot_sum[OWNER_W-1:0];
      w_rot_take = ~w_rot_hit & bus.request_valid_packed_in[w_rot_cand];
      w_rot_idx  = w_rot_take ? w_rot_cand : w_rot_idx;
      w_rot_hit  = w_rot_hit | w_rot_take;
    end
  end

`ifdef STARVE_GUARD_EN
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [7:0] r_starve_cnt [NUM_REQUESTS];

  // Lowest-index valid requester whose wait count reached the limit.
  always_comb begin
    w_starve_hit = 1'b0;
    w_starve_idx = '0;
    for (int i = NUM_REQUESTS - 1; i >= 0; i--) begin
      if (bus.request_valid_packed_in[i] && (r_starve_cnt[i] == STARVE_MAX)) begin
        w_starve_hit = 1'b1;
        w_starve_idx = OWNER_W'(i);
      end else begin
        w_starve_hit = w_starve_hit;
      end
    end
  end

  // Wait counters advance only on captures: cleared on grant or idle, else saturate.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_REQUESTS; i++) begin
        r_starve_cnt[i] <= 8'd0;
      end
    end else if (w_capture) begin
      for (int i = 0; i < NUM_REQUESTS; i++) begin
        if (w_grant_onehot[i] || !bus.request_valid_packed_in[i]) begin
          r_starve_cnt[i] <= 8'd0;
        end else if (r_starve_cnt[i] != STARVE_MAX) begin
          r_starve_cnt[i] <= r_starve_cnt[i] + 8'd1;
        end else begin
          r_starve_cnt[i] <= r_starve_cnt[i];
        end
      end
    end else begin
      for (int i = 0; i < NUM_REQUESTS; i++) begin
        r_starve_cnt[i] <= r_starve_cnt[i];
      end
    end
  end
`else
  logic w_unused_starve_limit;

  // Without the guard the order is pure weighted round-robin.
  assign w_starve_hit          = 1'b0;
  assign w_starve_idx          = '0;
  assign w_unused_starve_limit = ^(8'(STARVE_LIMIT));
`endif

  // Winner selection: starved first, then owner continuation, then rotation.
  always_comb begin
    w_continue = bus.request_valid_packed_in[r_owner] && (r_credit != {WW{1'b0}});
    w_rotate   = 1'b1;
    w_winner   = w_rot_idx;
    if (w_starve_hit) begin
      w_winner = w_starve_idx;
      w_rotate = 1'b1;
    end else if (w_continue) begin
      w_winner = r_owner;
      w_rotate = 1'b0;
    end else begin
      w_winner = w_rot_idx;
      w_rotate = 1'b1;
    end
  end

  // One-hot of the winner, AND-OR mux of its payload and weight.
  always_comb begin
    w_grant_onehot = '0;
    w_payload      = '0;
    w_win_weight   = '0;
    for (int i = 0; i < NUM_REQUESTS; i++) begin
      w_grant_onehot[i] = (w_winner == OWNER_W'(i));
      w_payload    = w_payload |
                     (bus.request_packed_in[i*PW +: PW] & {PW{w_grant_onehot[i]}});
      w_win_weight = w_win_weight |
                     (bus.request_weight_packed_in[i*WW +: WW] & {WW{w_grant_onehot[i]}});
    end
  end

  // Output stage, owner and credit: capture, drain when free, hold when stalled.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_request_out   <= {PW{1'b0}};
      r_request_valid <= 1'b0;
      r_owner         <= LAST_IDX;
      r_credit        <= {WW{1'b0}};
    end else if (w_capture) begin
      r_request_out   <= w_payload;
      r_request_valid <= 1'b1;
      if (w_rotate) begin
        r_owner  <= w_winner;
        r_credit <= reload_credit(w_win_weight);
      end else begin
        r_owner  <= r_owner;
        r_credit <= r_credit - WW'(1);
      end
    end else if (w_slot_free) begin
      r_request_out   <= r_request_out;
      r_request_valid <= 1'b0;
      r_owner         <= r_owner;
      r_credit        <= r_credit;
    end else begin
      r_request_out   <= r_request_out;
      r_request_valid <= r_request_valid;
      r_owner         <= r_owner;
      r_credit        <= r_credit;
    end
  end

  assign bus.issue_ack_out     = w_capture ? w_grant_onehot : {NUM_REQUESTS{1'b0}};
  assign bus.request_out       = r_request_out;
  assign bus.request_valid_out = r_request_valid;
  assign bus.owner_out         = r_owner;
endmodule

// File: tb/tb_weighted_rr_issue_scheduler.sv
// tb_weighted_rr_issue_scheduler
// Self-checking bench for weighted_rr_issue_scheduler (N=3, STARVE_LIMIT=4).
// Expected grant orders are queued when stimulus is applied and popped as
// consume pulses appear. Expectations follow STARVE_GUARD_EN if it is defined.
module tb_weighted_rr_issue_scheduler;
  localparam int N   = 3;
  localparam int W   = 64;
  localparam int WW  = 4;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  weighted_rr_issue_scheduler_if #(
    .NUM_REQUESTS(N), .SINGLE_REQUEST_WIDTH_IN_BITS(W), .WEIGHT_WIDTH(WW)
  ) bus ();

  weighted_rr_issue_scheduler #(
    .NUM_REQUESTS(N), .SINGLE_REQUEST_WIDTH_IN_BITS(W), .WEIGHT_WIDTH(WW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk_in  (clk),
    .reset_in(rst),
    .bus     (bus)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  logic [55:0] src_seq [N];
  int          exp_q   [$];

  task automatic drive_payloads();
    for (int i = 0; i < N; i++) begin
      bus.request_packed_in[i*W +: W] = {8'(i), src_seq[i]};
    end
  endtask

  task automatic consume(input logic [N-1:0] ack);
    for (int i = 0; i < N; i++) begin
      if (ack[i]) src_seq[i] = src_seq[i] + 56'd1;
    end
    drive_payloads();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.request_valid_packed_in = '0;
    bus.issue_ack_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.request_weight_packed_in = 12'h111;
    bus.request_valid_packed_in  = 3'b111;
    bus.issue_ack_in             = 1'b1;
    drive_payloads();
    @(posedge clk); #1;
    n_total++;
    if (bus.request_valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.request_valid_out);
    else n_pass++;
    n_total++;
    if (bus.request_out !== 64'd0) $display("FAIL reset_request_out got %h want 0", bus.request_out);
    else n_pass++;
    n_total++;
    if (bus.owner_out !== 2'd2) $display("FAIL reset_owner got %0d want 2", bus.owner_out);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.issue_ack_out !== 3'b000) $display("FAIL reset_issue_ack got %b want 000", bus.issue_ack_out);
    else n_pass++;
  endtask

  // Caller loads exp_q with the grant order it expects for these weights.
  task automatic test_weighted_rr(input string name, input logic [11:0] weights);
    int               e;
    int               k;
    logic [N-1:0]     ack;
    logic [N-1:0]     oh;
    logic [W-1:0]     exp_pl;
    do_reset();
    bus.request_weight_packed_in = weights;
    bus.request_valid_packed_in  = 3'b111;
    bus.issue_ack_in             = 1'b1;
    drive_payloads();
    k = 0;
    while (exp_q.size() != 0) begin
      e      = exp_q.pop_front();
      oh     = {{(N-1){1'b0}}, 1'b1} << e;
      exp_pl = {8'(e), src_seq[e]};
      @(negedge clk);
      ack = bus.issue_ack_out;
      n_total++;
      if (ack !== oh) $display("FAIL %s grant%0d issue_ack_out got %b want %b", name, k, ack, oh);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (bus.request_valid_out !== 1'b1 || bus.request_out !== exp_pl)
        $display("FAIL %s grant%0d out got v=%b %h want v=1 %h", name, k,
                 bus.request_valid_out, bus.request_out, exp_pl);
      else n_pass++;
      n_total++;
      if (bus.owner_out !== 2'(e)) $display("FAIL %s grant%0d owner got %0d want %0d", name, k, bus.owner_out, e);
      else n_pass++;
      consume(ack);
      k++;
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    do_reset();
    bus.request_weight_packed_in = 12'h111;
    bus.request_valid_packed_in  = 3'b010;
    bus.issue_ack_in             = 1'b1;
    drive_payloads();
    held = {8'd1, src_seq[1]};
    @(negedge clk);
    n_total++;
    if (bus.issue_ack_out !== 3'b010) $display("FAIL bp_first_ack got %b want 010", bus.issue_ack_out);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.request_valid_out !== 1'b1 || bus.request_out !== held || bus.owner_out !== 2'd1)
      $display("FAIL bp_first_out got v=%b %h o=%0d want v=1 %h o=1", bus.request_valid_out, bus.request_out, bus.owner_out, held);
    else n_pass++;
    consume(3'b010);
    bus.issue_ack_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_total++;
      if (bus.issue_ack_out !== 3'b000) $display("FAIL bp_stall%0d ack got %b want 000", c, bus.issue_ack_out);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (bus.request_valid_out !== 1'b1 || bus.request_out !== held)
        $display("FAIL bp_stall%0d out got v=%b %h want v=1 %h", c, bus.request_valid_out, bus.request_out, held);
      else n_pass++;
    end
    bus.issue_ack_in = 1'b1;
    held = {8'd1, src_seq[1]};
    @(negedge clk);
    n_total++;
    if (bus.issue_ack_out !== 3'b010) $display("FAIL bp_second_ack got %b want 010", bus.issue_ack_out);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.request_valid_out !== 1'b1 || bus.request_out !== held)
      $display("FAIL bp_second_out got v=%b %h want v=1 %h", bus.request_valid_out, bus.request_out, held);
    else n_pass++;
    consume(3'b010);
    bus.request_valid_packed_in = 3'b000;
    @(negedge clk);
    n_total++;
    if (bus.issue_ack_out !== 3'b000) $display("FAIL bp_idle_ack got %b want 000", bus.issue_ack_out);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.request_valid_out !== 1'b0) $display("FAIL bp_drain_valid got %b want 0", bus.request_valid_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid_transfer();
    logic [W-1:0] exp_pl;
    do_reset();
    bus.request_weight_packed_in = 12'h111;
    bus.request_valid_packed_in  = 3'b111;
    bus.issue_ack_in             = 1'b0;
    drive_payloads();
    @(negedge clk);
    n_total++;
    if (bus.issue_ack_out !== 3'b001) $display("FAIL rm_first_ack got %b want 001", bus.issue_ack_out);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.request_valid_out !== 1'b1) $display("FAIL rm_pending_valid got %b want 1", bus.request_valid_out);
    else n_pass++;
    consume(3'b001);
    rst = 1'b1;
    bus.issue_ack_in = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.issue_ack_out !== 3'b000) $display("FAIL rm_reset_ack got %b want 000", bus.issue_ack_out);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.request_valid_out !== 1'b0 || bus.owner_out !== 2'd2)
      $display("FAIL rm_after_reset got v=%b o=%0d want v=0 o=2", bus.request_valid_out, bus.owner_out);
    else n_pass++;
    rst = 1'b0;
    exp_pl = {8'd0, src_seq[0]};
    @(negedge clk);
    n_total++;
    if (bus.issue_ack_out !== 3'b001) $display("FAIL rm_post_ack got %b want 001", bus.issue_ack_out);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.request_out !== exp_pl || bus.owner_out !== 2'd0)
      $display("FAIL rm_post_out got %h o=%0d want %h o=0", bus.request_out, bus.owner_out, exp_pl);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < N; i++) src_seq[i] = 56'(i * 256);
    bus.request_packed_in        = '0;
    bus.request_valid_packed_in  = '0;
    bus.request_weight_packed_in = '0;
    bus.issue_ack_in             = 1'b0;

    test_reset();

    exp_q = '{0, 1, 2, 0, 1, 2};
    test_weighted_rr("equal_weights", 12'h111);

    exp_q = '{0, 0, 0, 1, 2, 0, 0, 0};
    test_weighted_rr("weights_311", 12'h113);

`ifdef STARVE_GUARD_EN
    exp_q = '{0, 0, 0, 0, 1, 2, 0};
`else
    exp_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0};
`endif
    test_weighted_rr("starvation", 12'h11F);

    test_backpressure();
    test_reset_mid_transfer();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end
endmodule
